dup_rep: RTL and testbench

- Stream repeater. Each accepted upstream beat is emitted downstream a number of times set by a repeat count, with first/last framing regenerated on the output.
- Generalises the fixed-count duplicator in two ways: repeat-count width is a parameter, and the count is latched per packet.
- Output data is registered, and output flags are derived from a holding register.
- Sits between two stages that use the {again, first, last, vld} master flags and the {abt, bsy} slave flags.

---
 rtl/dup_rep.sv | 125 ++++++++++++
 tb/tb_dup_rep.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dup_rep.sv
// Stream repeater: each accepted upstream beat is re-emitted n_lat times with regenerated first/last framing.
// Optional macro DUP_REP_ABT_FLUSH_EN: a downstream abort flushes the held beat and any remaining copies.
module dup_rep #(
   parameter int W  = 32,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] N,
   input  logic [W-1:0]  uc_d0,
   input  logic [3:0]    uc_mflags,
   output logic [1:0]    cu_sflags,
   output logic [W-1:0]  cd_d0,
   output logic [3:0]    cd_mflags,
   input  logic [1:0]    dc_sflags,
   output logic [CW-1:0] rep_idx
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  hold_d_q, hold_d_d;
   logic          hold_f_q, hold_f_d;
   logic          hold_l_q, hold_l_d;
   logic [CW-1:0] n_lat_q, n_lat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cd_again_q, cd_again_d;

   logic uc_vld, uc_first, uc_last;
   logic dc_bsy, dc_abt;
   logic emit, final_copy, abort;
   logic cd_vld, cd_first, cd_last, cu_bsy;
   logic up_acc, dn_acc;
   logic unused_uc_again;

   assign uc_vld          = uc_mflags[0];
   assign uc_last         = uc_mflags[1];
   assign uc_first        = uc_mflags[2];
   assign unused_uc_again = uc_mflags[3];
   assign dc_bsy          = dc_sflags[0];
   assign dc_abt          = dc_sflags[1];

`ifdef DUP_REP_ABT_FLUSH_EN
   assign abort = dc_abt;
`else
   assign abort = 1'b0;
`endif

   // n_lat is already updated by the accepting edge, so it is the effective count for the held beat.
   assign emit       = (state_q == EMIT);
   assign final_copy = emit & (cnt_q == n_lat_q);
   assign cd_vld     = emit;
   assign cd_first   = emit & hold_f_q & (cnt_q == CW'(1));
   assign cd_last    = final_copy & hold_l_q;
   assign cu_bsy     = (emit & ~(final_copy & ~dc_bsy)) | abort;
   assign up_acc     = uc_vld & ~cu_bsy;
   assign dn_acc     = cd_vld & ~dc_bsy;

   assign cu_sflags = {dc_abt, cu_bsy};
   assign cd_d0     = hold_d_q;
   assign cd_mflags = {cd_again_q, cd_first, cd_last, cd_vld};
   assign rep_idx   = emit ? cnt_q : '0;

   always_comb begin
      // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
      state_d    = state_q;
      hold_d_d   = hold_d_q;
      hold_f_d   = hold_f_q;
      hold_l_d   = hold_l_q;
      n_lat_d    = n_lat_q;
      cnt_d      = cnt_q;
      cd_again_d = 1'b0;

      if (up_acc && uc_first) begin
         n_lat_d = (N == '0) ? CW'(1) : N;
      end

      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         cd_again_d = cd_vld & dc_bsy;
         if (up_acc) begin
            // Only reachable from IDLE or on the final accepted copy, so reload is always safe.
            state_d  = EMIT;
            hold_d_d = uc_d0;
            hold_f_d = uc_first;
            hold_l_d = uc_last;
            cnt_d    = CW'(1);
         end else if (dn_acc) begin
            if (final_copy) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; all logic lives in the always_comb above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_d_q   <= '0;
         hold_f_q   <= 1'b0;
         hold_l_q   <= 1'b0;
         n_lat_q    <= CW'(1);
         cnt_q      <= '0;
         cd_again_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_d_q   <= hold_d_d;
         hold_f_q   <= hold_f_d;
         hold_l_q   <= hold_l_d;
         n_lat_q    <= n_lat_d;
         cnt_q      <= cnt_d;
         cd_again_q <= cd_again_d;
      end
   end

endmodule

// File: tb/tb_dup_rep.sv
// Self-checking bench for dup_rep: directed scenarios plus random traffic against a copy-queue model.
// Build with +define+DUP_REP_ABT_FLUSH_EN to exercise the abort flush.
module tb_dup_rep;
   localparam int W  = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] n_in;
   logic [W-1:0]  uc_d0;
   logic [3:0]    uc_mflags;
   logic [1:0]    cu_sflags;
   logic [W-1:0]  cd_d0;
   logic [3:0]    cd_mflags;
   logic [1:0]    dc_sflags;
   logic [CW-1:0] rep_idx;

   dup_rep #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .N         (n_in),
      .uc_d0     (uc_d0),
      .uc_mflags (uc_mflags),
      .cu_sflags (cu_sflags),
      .cd_d0     (cd_d0),
      .cd_mflags (cd_mflags),
      .dc_sflags (dc_sflags),
      .rep_idx   (rep_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         f;
      logic         l;
   } beat_t;

   typedef struct {
      logic [W-1:0] d;
      logic         f;
      logic         l;
      int           idx;
   } copy_t;

   beat_t src_q[$];   // beats waiting to be offered upstream
   copy_t exp_q[$];   // every copy the DUT still owes downstream, in order
   int    n_model;
   logic  again_model;
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      src_q.delete();
      n_model     = 1;
      again_model = 1'b0;
   endtask

   task automatic add_pkt(input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = $urandom;
         b.f = (i == 0);
         b.l = (i == len - 1);
         src_q.push_back(b);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_cd_vld",   64'(cd_mflags[0]), 64'd0);
      chk("rst_cd_last",  64'(cd_mflags[1]), 64'd0);
      chk("rst_cd_first", 64'(cd_mflags[2]), 64'd0);
      chk("rst_cd_again", 64'(cd_mflags[3]), 64'd0);
      chk("rst_cu_bsy",   64'(cu_sflags[0]), 64'd0);
      chk("rst_cd_d0",    64'(cd_d0),        64'd0);
      chk("rst_rep_idx",  64'(rep_idx),      64'd0);
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic step(input logic bsy, input logic abt, input logic gap);
      logic  exp_vld, exp_bsy, up_acc, dn_acc, abort, uc_vld, uc_f, uc_l;
      copy_t c;
      int    n;
      uc_vld = (src_q.size() > 0) && !gap;
      uc_f   = uc_vld ? src_q[0].f : 1'($urandom);
      uc_l   = uc_vld ? src_q[0].l : 1'($urandom);
      uc_d0  = uc_vld ? src_q[0].d : $urandom;
      uc_mflags = {1'($urandom), uc_f, uc_l, uc_vld};
      dc_sflags = {abt, bsy};
      abort = 1'b0;
`ifdef DUP_REP_ABT_FLUSH_EN
      abort = abt;
`endif
      #1;
      exp_vld = (exp_q.size() > 0);
      exp_bsy = abort || (exp_q.size() > 1) || (exp_q.size() == 1 && bsy);
      chk("cd_vld", 64'(cd_mflags[0]), 64'(exp_vld));
      if (exp_vld) begin
         c = exp_q[0];
         chk("cd_d0",    64'(cd_d0),        64'(c.d));
         chk("cd_first", 64'(cd_mflags[2]), 64'(c.f));
         chk("cd_last",  64'(cd_mflags[1]), 64'(c.l));
         chk("rep_idx",  64'(rep_idx),      64'(c.idx));
      end else begin
         chk("idle_first",   64'(cd_mflags[2]), 64'd0);
         chk("idle_last",    64'(cd_mflags[1]), 64'd0);
         chk("idle_rep_idx", 64'(rep_idx),      64'd0);
      end
      chk("cd_again", 64'(cd_mflags[3]), 64'(again_model));
      chk("cu_bsy",   64'(cu_sflags[0]), 64'(exp_bsy));
      chk("cu_abt",   64'(cu_sflags[1]), 64'(abt));

      if (abort) begin
         exp_q.delete();
         again_model = 1'b0;
      end else begin
         again_model = exp_vld && bsy;
         up_acc = uc_vld && !exp_bsy;
         dn_acc = exp_vld && !bsy;
         if (dn_acc) void'(exp_q.pop_front());
         if (up_acc) begin
            if (uc_f) n_model = (n_in == 0) ? 1 : int'(n_in);
            n = n_model;
            for (int i = 1; i <= n; i++) begin
               c.d   = uc_d0;
               c.f   = uc_f && (i == 1);
               c.l   = uc_l && (i == n);
               c.idx = i;
               exp_q.push_back(c);
            end
            void'(src_q.pop_front());
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
         step(1'b0, 1'b0, 1'b0);
         k++;
      end
      chk("drain_timeout", 64'(src_q.size() + exp_q.size()), 64'd0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      n_in      = '0;
      uc_d0     = '0;
      uc_mflags = '0;
      dc_sflags = '0;
      model_reset();
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);

      // N=3, two-beat packet: A x3 then B x3.
      n_in = 8'd3;
      add_pkt(2);
      drain(40);

      // N=0 and N=1 behave as passthrough.
      n_in = 8'd0;
      add_pkt(3);
      drain(40);
      n_in = 8'd1;
      add_pkt(3);
      drain(40);

      // N=2 with downstream stalled two cycles on copy 2 of the first beat.
      n_in = 8'd2;
      add_pkt(2);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      drain(40);

      // N changes mid-packet: takes effect only at the next first beat.
      n_in = 8'd2;
      add_pkt(3);
      step(1'b0, 1'b0, 1'b0);
      n_in = 8'd4;
      drain(60);
      add_pkt(2);
      drain(60);

      // Asynchronous reset during copy 2 of 3.
      n_in = 8'd3;
      add_pkt(1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      add_pkt(2);
      drain(40);

      // Abort pulse during copy 1 of 3.
      n_in = 8'd3;
      add_pkt(1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      drain(40);

      // Random traffic: random N, gaps, stalls and rare aborts.
      for (int p = 0; p < 40; p++) begin
         add_pkt(int'($urandom_range(1, 4)));
         for (int k = 0; k < 200 && (src_q.size() > 0 || exp_q.size() > 0); k++) begin
            n_in = CW'($urandom_range(0, 4));
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 4) == 0));
         end
      end
      drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
